// File: rtl/bus_ram_responder.sv
// bus_ram_responder: memory-side responder for the 6502 core bus.
// It decodes an address window at BASE_ADDR and stalls the CPU through
// rdy for WAIT_STATES cycles. It then completes the access with a one-cycle
// ack pulse, either returning read data or committing write data.
// Optional feature macro: RAM_WRITE_PROTECT_EN adds the wp input and the
// wp_err output. When wp is high, a write handshakes normally but leaves
// the array untouched.
module bus_ram_responder #(
    parameter int          ADDR_WIDTH  = 12,
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [15:0] addr,
    input  logic        rw,
    input  logic [7:0]  wdata,
`ifdef RAM_WRITE_PROTECT_EN
    input  logic        wp,
    output logic        wp_err,
`endif
    output logic [7:0]  rdata,
    output logic        ack,
    output logic        rdy,
    output logic        sel
);

    localparam int         DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] WS_C  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [3:0]              cnt_r;
    logic [3:0]              cnt_s;
    logic [ADDR_WIDTH-1:0]   cap_addr_r;
    logic                    cap_rw_r;
    logic [7:0]              cap_wdata_r;
    logic [7:0]              mem_r [DEPTH];

    logic                    hit_s;
    logic                    enter_done_s;
    logic [ADDR_WIDTH-1:0]   op_addr_s;
    logic                    op_rw_s;
    logic [7:0]              op_wdata_s;
    logic                    wp_block_s;
    logic                    we_s;
    logic                    re_s;

    assign hit_s = req && (addr[15:ADDR_WIDTH] == BASE_ADDR[15:ADDR_WIDTH]);

`ifdef RAM_WRITE_PROTECT_EN
    assign wp_block_s = wp;
`else
    assign wp_block_s = 1'b0;
`endif

    // Next-state logic and counter; flags the edge that enters DONE.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        enter_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (hit_s) begin
                    if (WS_C == 4'd0) begin
                        state_s      = DONE;
                        enter_done_s = 1'b1;
                    end else begin
                        state_s = WAIT;
                        cnt_s   = WS_C;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd1) begin
                    state_s      = DONE;
                    cnt_s        = 4'd0;
                    enter_done_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // With zero wait states the access completes on the capture edge, so
    // the live bus is used; otherwise the captured copy is used.
    always_comb begin
        if (state_r == IDLE) begin
            op_addr_s  = addr[ADDR_WIDTH-1:0];
            op_rw_s    = rw;
            op_wdata_s = wdata;
        end else begin
            op_addr_s  = cap_addr_r;
            op_rw_s    = cap_rw_r;
            op_wdata_s = cap_wdata_r;
        end
    end

    // A write is never committed while reset is asserted.
    assign we_s = enter_done_s & ~op_rw_s & ~wp_block_s & rst_n;
    assign re_s = enter_done_s & op_rw_s;

    // State register, capture registers and registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            cap_addr_r  <= '0;
            cap_rw_r    <= 1'b1;
            cap_wdata_r <= 8'h00;
            rdata       <= 8'h00;
            ack         <= 1'b0;
            rdy         <= 1'b1;
            sel         <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ack     <= enter_done_s;
            rdy     <= (state_s != WAIT);
            if (state_r == IDLE && req) begin
                sel <= hit_s;
            end
            if (state_r == IDLE && hit_s) begin
                cap_addr_r  <= addr[ADDR_WIDTH-1:0];
                cap_rw_r    <= rw;
                cap_wdata_r <= wdata;
            end
            if (re_s) begin
                rdata <= mem_r[op_addr_s];
            end
        end
    end

    // Byte array: not reset, so contents are undefined after power-up.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[op_addr_s] <= op_wdata_s;
        end
    end

`ifdef RAM_WRITE_PROTECT_EN
    // Error pulse that accompanies the ack of a blocked write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_err <= 1'b0;
        end else begin
            wp_err <= enter_done_s & ~op_rw_s & wp;
        end
    end
`endif

endmodule

// File: tb/tb_bus_ram_responder.sv
// Bench for bus_ram_responder: four instances with different windows and
// wait-state counts share one bus. A transaction-level model predicts ack,
// rdy, sel, rdata (and wp_err when RAM_WRITE_PROTECT_EN is defined) on
// every cycle. Directed accesses pin latencies and data to literal values.
module tb_bus_ram_responder;

    localparam int          N = 4;
    localparam int          AW_T   [N] = '{12, 12, 8, 10};
    localparam logic [15:0] BASE_T [N] = '{16'h0000, 16'h8000, 16'h4000, 16'hC000};
    localparam int          WS_T   [N] = '{1, 3, 0, 4};

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        req   = 1'b0;
    logic [15:0] addr  = 16'h0000;
    logic        rw    = 1'b1;
    logic [7:0]  wdata = 8'h00;
    logic [7:0]  rdata_w [N];
    logic        ack_w   [N];
    logic        rdy_w   [N];
    logic        sel_w   [N];
`ifdef RAM_WRITE_PROTECT_EN
    logic        wp = 1'b0;
    logic        wperr_w [N];
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        bus_ram_responder #(
            .ADDR_WIDTH (AW_T[g]),
            .BASE_ADDR  (BASE_T[g]),
            .WAIT_STATES(WS_T[g])
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .req   (req),
            .addr  (addr),
            .rw    (rw),
            .wdata (wdata),
`ifdef RAM_WRITE_PROTECT_EN
            .wp    (wp),
            .wp_err(wperr_w[g]),
`endif
            .rdata (rdata_w[g]),
            .ack   (ack_w[g]),
            .rdy   (rdy_w[g]),
            .sel   (sel_w[g])
        );
    end

    task automatic chk(input string name, input int d, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", name, d, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         cyc = 0;
    bit   [7:0] mm [N][4096];
    bit         mv [N][4096];
    bit         pend [N];
    int         start_e [N];
    int         done_e [N];
    bit         p_rw [N];
    int         p_idx [N];
    bit   [7:0] p_wd [N];
    bit         e_sel [N];
    bit   [7:0] e_rd [N];
    bit         rd_known [N];
    bit         e_wpe [N];

    function automatic bit in_win(int d, logic [15:0] a);
        return (32'(a) >> AW_T[d]) == (32'(BASE_T[d]) >> AW_T[d]);
    endfunction

    function automatic bit wp_now();
`ifdef RAM_WRITE_PROTECT_EN
        return wp;
`else
        return 1'b0;
`endif
    endfunction

    // Advance the model one edge, then compare every DUT output.
    always @(posedge clk) begin
        #1;
        cyc++;
        for (int d = 0; d < N; d++) begin
            e_wpe[d] = 1'b0;
            if (!rst_n) begin
                pend[d]     = 1'b0;
                done_e[d]   = -100;
                e_sel[d]    = 1'b0;
                e_rd[d]     = 8'h00;
                rd_known[d] = 1'b1;
            end else begin
                if (!pend[d] && cyc >= done_e[d] + 2 && req) begin
                    e_sel[d] = in_win(d, addr);
                    if (e_sel[d]) begin
                        pend[d]    = 1'b1;
                        start_e[d] = cyc;
                        done_e[d]  = cyc + WS_T[d];
                        p_rw[d]    = rw;
                        p_idx[d]   = int'(addr) & ((1 << AW_T[d]) - 1);
                        p_wd[d]    = wdata;
                    end
                end
                if (pend[d] && cyc == done_e[d]) begin
                    pend[d] = 1'b0;
                    if (p_rw[d]) begin
                        rd_known[d] = mv[d][p_idx[d]];
                        e_rd[d]     = mm[d][p_idx[d]];
                    end else if (wp_now()) begin
                        e_wpe[d] = 1'b1;
                    end else begin
                        mm[d][p_idx[d]] = p_wd[d];
                        mv[d][p_idx[d]] = 1'b1;
                    end
                end
            end
            chk("ack", d, int'(ack_w[d]), int'(cyc == done_e[d]));
            chk("rdy", d, int'(rdy_w[d]),
                int'(!(pend[d] && cyc >= start_e[d] && cyc < done_e[d])));
            chk("sel", d, int'(sel_w[d]), int'(e_sel[d]));
            if (rd_known[d]) begin
                chk("rdata", d, int'(rdata_w[d]), int'(e_rd[d]));
            end
`ifdef RAM_WRITE_PROTECT_EN
            chk("wp_err", d, int'(wperr_w[d]), int'(e_wpe[d]));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic access(input logic [15:0] a, input logic r, input logic [7:0] wd,
                          output int lat, output logic [7:0] rd, output logic err);
        @(negedge clk);
        req   = 1'b1;
        addr  = a;
        rw    = r;
        wdata = wd;
        lat   = -1;
        rd    = 8'h00;
        err   = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            for (int d = 0; d < N; d++) begin
                if (ack_w[d] && lat < 0) begin
                    lat = k;
                    rd  = rdata_w[d];
`ifdef RAM_WRITE_PROTECT_EN
                    err = wperr_w[d];
`endif
                end
            end
            if (lat >= 0) begin
                break;
            end
            addr  = {a[15:8], 8'($urandom)};
            rw    = 1'($urandom);
            wdata = 8'($urandom);
        end
        req = 1'b0;
        @(negedge clk);
    endtask

    int         lat;
    logic [7:0] rd;
    logic       err;

    initial begin
        // Reset held with a live request on the bus.
        req  = 1'b1;
        addr = 16'h0123;
        rw   = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        req   = 1'b0;
        repeat (3) @(negedge clk);

        // One wait state, window at 0000.
        access(16'h0123, 1'b0, 8'hA5, lat, rd, err);
        chk("lit_wr_lat_ws1", 0, lat, 2);
        access(16'h0123, 1'b1, 8'h00, lat, rd, err);
        chk("lit_rd_lat_ws1", 0, lat, 2);
        chk("lit_rd_data_ws1", 0, int'(rd), 8'hA5);

        // Miss for every window.
        access(16'h1234, 1'b1, 8'h00, lat, rd, err);
        chk("lit_miss_noack", 1, lat, -1);
        chk("lit_miss_sel", 1, int'(sel_w[1]), 0);
        chk("lit_miss_rdy", 1, int'(rdy_w[1]), 1);

        // Three wait states; the task toggles ADDR/RW during WAIT.
        access(16'h8456, 1'b0, 8'h3C, lat, rd, err);
        chk("lit_wr_lat_ws3", 1, lat, 4);
        access(16'h8456, 1'b1, 8'h00, lat, rd, err);
        chk("lit_rd_lat_ws3", 1, lat, 4);
        chk("lit_rd_data_ws3", 1, int'(rd), 8'h3C);

        // Zero wait states.
        access(16'h4077, 1'b0, 8'h99, lat, rd, err);
        chk("lit_wr_lat_ws0", 2, lat, 1);
        access(16'h4077, 1'b1, 8'h00, lat, rd, err);
        chk("lit_rd_lat_ws0", 2, lat, 1);
        chk("lit_rd_data_ws0", 2, int'(rd), 8'h99);

        // Reset pulse in the middle of a four-wait-state write.
        access(16'hC010, 1'b0, 8'h33, lat, rd, err);
        chk("lit_wr_lat_ws4", 3, lat, 5);
        @(negedge clk);
        req   = 1'b1;
        addr  = 16'hC010;
        rw    = 1'b0;
        wdata = 8'h5A;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        access(16'hC010, 1'b1, 8'h00, lat, rd, err);
        chk("lit_abort_rd_data", 3, int'(rd), 8'h33);

`ifdef RAM_WRITE_PROTECT_EN
        access(16'h0040, 1'b0, 8'h11, lat, rd, err);
        wp = 1'b1;
        access(16'h0040, 1'b0, 8'hFF, lat, rd, err);
        chk("lit_wp_lat", 0, lat, 2);
        chk("lit_wp_err", 0, int'(err), 1);
        wp = 1'b0;
        access(16'h0040, 1'b1, 8'h00, lat, rd, err);
        chk("lit_wp_rd_data", 0, int'(rd), 8'h11);
`endif

        // Random traffic across all windows plus misses.
        for (int i = 0; i < 200; i++) begin
            int          d;
            logic [15:0] a;
            d = int'($urandom_range(0, 4));
            if (d == 4) begin
                a = ($urandom_range(0, 1) == 0) ? (16'h1000 | 16'($urandom_range(0, 4095)))
                                                : (16'hC400 | 16'($urandom_range(0, 1023)));
            end else if ($urandom_range(0, 3) == 0) begin
                a = BASE_T[d] | 16'($urandom & ((1 << AW_T[d]) - 1));
            end else begin
                a = BASE_T[d] | 16'($urandom_range(0, 15));
            end
`ifdef RAM_WRITE_PROTECT_EN
            wp = ($urandom_range(0, 3) == 0);
`endif
            access(a, 1'($urandom), 8'($urandom), lat, rd, err);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
